// File: rtl/fp16_pkg.sv
// Shared widths, constants and state encoding for the fp16 calculator datapath.
package fp16_pkg;

  localparam int N = 11;
  localparam int E = 5;
  localparam logic [4:0] EXP_MAX = 5'h1F;
  localparam int BIAS = 15;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_t;

endpackage

// File: rtl/fp16_normalizer.sv
// Post-adder normalizer: consumes the adder carry once, then left-shifts one bit per
// cycle until normalized, zero or subnormal, and packs a half-precision result.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one normalization rule evaluated per cycle
// DONE  | result held with out_valid high until out_ready
module fp16_normalizer
  import fp16_pkg::*;
#(
  parameter int N = fp16_pkg::N,
  parameter int E = fp16_pkg::E
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sign,
  input  logic [E-1:0]   in_exp,
  input  logic [N-1:0]   in_sig,
  input  logic           in_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [E+N-1:0] out_result,
  output logic           out_overflow,
  output logic           out_zero
);

  localparam logic [E-1:0] EXP_ALL1 = '1;
  localparam logic [E-1:0] EXP_ONE  = E'(1);

  norm_state_t      state_q, state_d;
  logic             sign_q, sign_d;
  logic             cout_q, cout_d;
  logic [E-1:0]     exp_q, exp_d;
  logic [N-1:0]     sig_q, sig_d;
  logic [E+N-1:0]   res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [E-1:0]     exp_inc;
  logic [N-1:0]     sig_rsh;

  // Right shift reinserts the carry as the new hidden bit; the dropped LSB is truncated.
  assign exp_inc = exp_q + 1'b1;
  assign sig_rsh = {1'b1, sig_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      cout_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      cout_q  <= cout_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    cout_d  = cout_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          sign_d  = in_sign;
          cout_d  = in_cout;
          exp_d   = in_exp;
          sig_d   = in_sig;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (cout_q) begin
          cout_d  = 1'b0;
          sig_d   = sig_rsh;
          exp_d   = exp_inc;
          state_d = DONE;
          if (exp_inc == EXP_ALL1) begin
            res_d = {sign_q, EXP_ALL1, {(N-1){1'b0}}};
            ovf_d = 1'b1;
          end else begin
            res_d = {sign_q, exp_inc, sig_rsh[N-2:0]};
          end
        end else if (sig_q == '0) begin
          res_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (sig_q[N-1]) begin
          res_d   = {sign_q, exp_q, sig_q[N-2:0]};
          state_d = DONE;
        end else if (exp_q <= EXP_ONE) begin
          res_d   = {sign_q, {E{1'b0}}, sig_q[N-2:0]};
          state_d = DONE;
        end else begin
          sig_d = sig_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule
